spindle_contactor_monitor: RTL and testbench
============================================

// Module: spindle_contactor_monitor
// PURPOSE
//  Actuator-side end of the spindle run command. Consumes the 1-bit run request from the
//  AUTO/MAN lathe controller and drives the spindle contactor and brake. Proves the
//  request took effect via the contactor auxiliary feedback contact.
//  Latches a coded fault on missing, lost or stuck feedback.
// PARAMETERS
//  DEBOUNCE_CYC   2_500_000    stable cycles before feedback change accepted (50 ms @ 50 MHz)
//  START_TIMEOUT  25_000_000   max cycles in STARTING awaiting feedback (0.5 s)
//  BRAKE_CYC      100_000_000  cycles brake held in STOPPING (2 s); all params >= 2
// PORTS
//  clk        in   1  system clock, 50 MHz
//  reset      in   1  synchronous, active-high
//  cmd_run    in   1  run request from controller (level)
//  fb_raw     in   1  contactor aux contact, asynchronous, 1 = closed
//  fault_clr  in   1  operator fault acknowledge (level, sampled)
//  contactor  out  1  spindle contactor coil drive
//  brake      out  1  spindle brake drive
//  running    out  1  run confirmed by feedback
//  fault      out  1  latched fault
//  fault_code out  2  00 none, 01 start timeout, 10 feedback lost, 11 feedback stuck
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, sync flops 0, fb_db 0, all counters 0.
//  Feedback path
//  - fb_raw -> 2-flop synchroniser -> fb_s.
//  - fb_s == fb_db: debounce count cleared.
//  - Otherwise count++. On the cycle count == DEBOUNCE_CYC-1: fb_db <= fb_s, count <= 0.
//  - fb_db follows a clean edge exactly 2+DEBOUNCE_CYC cycles after fb_raw.
//  - Glitch shorter than DEBOUNCE_CYC: fb_db does not change.
//  Timer
//  - One state timer, cleared on every state change, else increments.
//  - Width $clog2(max(START_TIMEOUT,BRAKE_CYC)+1).
//  - Expiry = timer == P-1, i.e. exactly P cycles spent in the state.
//  FSM: all outputs registered, set on the same edge as the state change.
//  Priority within a state is the listed order.
//  - IDLE      (con 0, brk 0, run 0)
//    fb_db=1 -> FAULT/11; cmd_run=1 -> STARTING.
//  - STARTING  (con 1, brk 0)
//    cmd_run=0 -> STOPPING; fb_db=1 -> RUNNING; expiry -> FAULT/01.
//  - RUNNING   (con 1, brk 0, run 1)
//    fb_db=0 -> FAULT/10 (also when cmd_run=0 same cycle); cmd_run=0 -> STOPPING.
//  - STOPPING  (con 0, brk 1)
//    held BRAKE_CYC cycles; cmd_run ignored.
//    On expiry: fb_db=0 -> IDLE, else FAULT/11.
//  - FAULT     (con 0, brk 1, fault 1, fault_code held)
//    -> IDLE only when fault_clr=1 & cmd_run=0 & fb_db=0; otherwise stays.
//    fault_code is cleared on that exit.
//  Latency: cmd_run high in IDLE -> contactor=1 one clock later.
//  contactor and brake are never both 1 in any cycle.
//  Reset mid-operation: next edge forces the reset values.
//  - contactor drops immediately, brake is not held.
// STRUCTURE
//  Shared package lathe_pkg:
//  - state encoding: IDLE, STARTING, RUNNING, STOPPING, FAULT
//  - fault codes: FLT_NONE, FLT_START_TO, FLT_FB_LOST, FLT_FB_STUCK
//  Sub-module fb_debounce (param DEBOUNCE_CYC): synchroniser + debounce, output fb_db.
//  FSM, timer and output registers live in this module.
// TESTING (DEBOUNCE_CYC=4, START_TIMEOUT=20, BRAKE_CYC=10)
//  1 Normal cycle:
//    cmd_run=1 @t0 -> contactor=1 @t0+1.
//    fb_raw=1 @t0+3 -> running=1 @t0+10.
//    cmd_run=0 -> brake=1 for 10 cycles.
//    fb_raw=0 within brake -> IDLE, all outputs 0.
//  2 Start timeout: cmd_run=1, fb_raw held 0 -> fault=1, fault_code=01 at 20 cycles in STARTING.
//    contactor=0, brake=1 on that edge.
//  3 Feedback loss: in RUNNING, fb_raw=0 for 6 cycles -> fault_code=10.
//    A 3-cycle fb_raw=0 glitch -> no fault.
//  4 Welded contactor: fb_raw=1 throughout STOPPING -> fault_code=11 after 10 brake cycles.
//    Also: fb_raw=1 while IDLE -> fault_code=11.
//  5 Fault clear gating: fault_clr=1 while cmd_run=1 -> stays FAULT.
//    cmd_run=0, fb_db=0, fault_clr=1 -> IDLE, fault=0, fault_code=00.
//  6 Reset mid-RUNNING: reset=1 one cycle -> all outputs 0 next edge.
//    Debounce restarts; fb_raw=1 held -> FAULT/11 after 6 cycles.

Source files
------------

// File: rtl/lathe_pkg.sv
// lathe_pkg: shared state encoding and fault codes for the lathe spindle control path
package lathe_pkg;
  typedef enum logic [2:0] {IDLE, STARTING, RUNNING, STOPPING, FAULT} state_e;
  typedef enum logic [1:0] {
    FLT_NONE     = 2'b00,
    FLT_START_TO = 2'b01,
    FLT_FB_LOST  = 2'b10,
    FLT_FB_STUCK = 2'b11
  } fault_e;
endpackage

// File: rtl/fb_debounce.sv
// fb_debounce: two-flop synchroniser plus stable-count debounce of the contactor aux contact
module fb_debounce #(
  parameter int DEBOUNCE_CYC = 2_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic fb_raw,
  output logic fb_db
);
  localparam int CW = $clog2(DEBOUNCE_CYC);
  logic s1, fb_s;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      fb_s  <= 1'b0;
      fb_db <= 1'b0;
      cnt   <= '0;
    end else begin
      s1   <= fb_raw;
      fb_s <= s1;
      if (fb_s == fb_db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        fb_db <= fb_s;
        cnt   <= '0;
      end else cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/spindle_contactor_monitor.sv
// spindle_contactor_monitor: drives spindle contactor/brake and proves the run via aux feedback
module spindle_contactor_monitor
  import lathe_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = 2_500_000,
  parameter int START_TIMEOUT = 25_000_000,
  parameter int BRAKE_CYC     = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_run,
  input  logic       fb_raw,
  input  logic       fault_clr,
  output logic       contactor,
  output logic       brake,
  output logic       running,
  output logic       fault,
  output logic [1:0] fault_code
);
  localparam int TMAX = (START_TIMEOUT > BRAKE_CYC) ? START_TIMEOUT : BRAKE_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  state_e state_q, state_d;
  fault_e code_q, code_d;
  logic [TW-1:0] timer;
  logic fb_db, start_exp, brake_exp;
  fb_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_fb (
    .clk(clk), .reset(reset), .fb_raw(fb_raw), .fb_db(fb_db)
  );
  assign start_exp  = timer == TW'(START_TIMEOUT - 1);
  assign brake_exp  = timer == TW'(BRAKE_CYC - 1);
  assign fault_code = code_q;
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      IDLE:
        if (fb_db) begin
          state_d = FAULT;
          code_d  = FLT_FB_STUCK;
        end else if (cmd_run) state_d = STARTING;
      STARTING:
        if (!cmd_run) state_d = STOPPING;
        else if (fb_db) state_d = RUNNING;
        else if (start_exp) begin
          state_d = FAULT;
          code_d  = FLT_START_TO;
        end
      RUNNING:
        if (!fb_db) begin
          state_d = FAULT;
          code_d  = FLT_FB_LOST;
        end else if (!cmd_run) state_d = STOPPING;
      STOPPING:
        if (brake_exp) begin
          state_d = fb_db ? FAULT : IDLE;
          code_d  = fb_db ? FLT_FB_STUCK : code_q;
        end
      FAULT:
        if (fault_clr && !cmd_run && !fb_db) begin
          state_d = IDLE;
          code_d  = FLT_NONE;
        end
      default: state_d = IDLE;
    endcase
  end
  // outputs decode the next state so they change on the same edge as the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      code_q    <= FLT_NONE;
      timer     <= '0;
      contactor <= 1'b0;
      brake     <= 1'b0;
      running   <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      timer     <= (state_d != state_q) ? '0 : timer + TW'(1);
      contactor <= (state_d == STARTING) || (state_d == RUNNING);
      brake     <= (state_d == STOPPING) || (state_d == FAULT);
      running   <= state_d == RUNNING;
      fault     <= state_d == FAULT;
    end
  end
endmodule

// File: tb/tb_spindle_contactor_monitor.sv
// tb_spindle_contactor_monitor: directed scenarios checked against a cycle model and literal pins
module tb_spindle_contactor_monitor;
  localparam int DEB = 4, STO = 20, BRK = 10;
  localparam int M_IDLE = 0, M_START = 1, M_RUN = 2, M_STOP = 3, M_FAULT = 4;
  logic clk = 1'b0, reset = 1'b1, cmd_run = 1'b0, fb_raw = 1'b0, fault_clr = 1'b0;
  logic contactor, brake, running, fault;
  logic [1:0] fault_code;
  int tests = 0, fails = 0;
  bit chk = 1'b0;
  int cyc = 0, ent = 0, mst = M_IDLE, mcode = 0, run = 0;
  logic s1 = 1'b0, s2 = 1'b0, db = 1'b0;

  spindle_contactor_monitor #(.DEBOUNCE_CYC(DEB), .START_TIMEOUT(STO), .BRAKE_CYC(BRK)) dut (
    .clk(clk), .reset(reset), .cmd_run(cmd_run), .fb_raw(fb_raw), .fault_clr(fault_clr),
    .contactor(contactor), .brake(brake), .running(running), .fault(fault),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // model: fb_raw seen through two sync stages, accepted after DEB consecutive differing samples;
  // state dwell measured as edges elapsed since entry
  always @(posedge clk) begin
    automatic int c = cyc + 1;
    automatic int st = mst, nst = mst, code = mcode, r = run, el = c - ent, e = ent;
    automatic logic d = db;
    if (reset) begin
      s1 <= 1'b0; s2 <= 1'b0; db <= 1'b0; run <= 0;
      mst <= M_IDLE; mcode <= 0; ent <= c;
    end else begin
      case (st)
        M_IDLE:  if (d) begin nst = M_FAULT; code = 3; end else if (cmd_run) nst = M_START;
        M_START: if (!cmd_run) nst = M_STOP; else if (d) nst = M_RUN;
                 else if (el == STO) begin nst = M_FAULT; code = 1; end
        M_RUN:   if (!d) begin nst = M_FAULT; code = 2; end else if (!cmd_run) nst = M_STOP;
        M_STOP:  if (el == BRK) begin nst = d ? M_FAULT : M_IDLE; if (d) code = 3; end
        default: if (fault_clr && !cmd_run && !d) begin nst = M_IDLE; code = 0; end
      endcase
      if (nst != st) e = c;
      if (s2 != d) begin
        r = r + 1;
        if (r == DEB) begin d = s2; r = 0; end
      end else r = 0;
      mst <= nst; mcode <= code; ent <= e; run <= r; db <= d;
      s2 <= s1; s1 <= fb_raw;
    end
    cyc <= c;
  end

  task automatic cmp(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk) begin
    cmp("model.contactor", contactor, int'(mst == M_START || mst == M_RUN));
    cmp("model.brake", brake, int'(mst == M_STOP || mst == M_FAULT));
    cmp("model.running", running, int'(mst == M_RUN));
    cmp("model.fault", fault, int'(mst == M_FAULT));
    cmp("model.fault_code", fault_code, mcode);
    cmp("interlock", int'(contactor & brake), 0);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_fault();
    cmd_run = 1'b0; fb_raw = 1'b0;
    step(8);
    fault_clr = 1'b1;
    step(1);
    cmp("clr.fault", fault, 0);
    fault_clr = 1'b0;
    step(2);
  endtask

  task automatic go_running();
    cmd_run = 1'b1; fb_raw = 1'b1;
    step(12);
    cmp("run.running", running, 1);
  endtask

  initial begin
    step(2);
    chk = 1'b1;
    cmp("reset.contactor", contactor, 0);
    cmp("reset.brake", brake, 0);
    reset = 1'b0;
    step(2);
    // 1 normal cycle
    cmd_run = 1'b1;
    step(1);
    cmp("n.contactor_t1", contactor, 1);
    step(2);
    fb_raw = 1'b1;
    step(6);
    cmp("n.running_t9", running, 0);
    step(1);
    cmp("n.running_t10", running, 1);
    cmd_run = 1'b0;
    step(1);
    cmp("n.brake_on", brake, 1);
    cmp("n.contactor_off", contactor, 0);
    fb_raw = 1'b0;
    step(9);
    cmp("n.brake_held", brake, 1);
    step(1);
    cmp("n.brake_released", brake, 0);
    cmp("n.fault", fault, 0);
    // 2 start timeout, 5 clear gating
    cmd_run = 1'b1;
    step(20);
    cmp("to.fault_t19", fault, 0);
    step(1);
    cmp("to.fault_t20", fault, 1);
    cmp("to.code", fault_code, 1);
    cmp("to.contactor", contactor, 0);
    fault_clr = 1'b1;
    step(3);
    cmp("gate.held", fault, 1);
    cmd_run = 1'b0;
    step(1);
    cmp("gate.released", fault, 0);
    cmp("gate.code", fault_code, 0);
    fault_clr = 1'b0;
    step(2);
    // 3 glitch then loss
    go_running();
    fb_raw = 1'b0;
    step(3);
    fb_raw = 1'b1;
    step(10);
    cmp("glitch.running", running, 1);
    cmp("glitch.fault", fault, 0);
    fb_raw = 1'b0;
    step(6);
    cmp("loss.fault_early", fault, 0);
    step(1);
    cmp("loss.code", fault_code, 2);
    clear_fault();
    // 4 welded contactor in STOPPING, then stuck in IDLE
    go_running();
    cmd_run = 1'b0;
    step(10);
    cmp("weld.fault_early", fault, 0);
    step(1);
    cmp("weld.code", fault_code, 3);
    clear_fault();
    fb_raw = 1'b1;
    step(8);
    cmp("stuck.code", fault_code, 3);
    clear_fault();
    // 6 reset mid-RUNNING
    go_running();
    reset = 1'b1;
    step(1);
    cmp("rst.contactor", contactor, 0);
    cmp("rst.brake", brake, 0);
    cmp("rst.running", running, 0);
    reset = 1'b0; cmd_run = 1'b0;
    step(6);
    cmp("rst.fault_early", fault, 0);
    step(1);
    cmp("rst.code", fault_code, 3);
    clear_fault();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
